// File: rtl/fulladder_pkg.sv
// Shared types and golden model for the full-adder built-in self test.
package fulladder_pkg;

  localparam int unsigned NUM_VEC = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Reference response {sum,cout} for input vector {a,b,cin}
  function automatic logic [1:0] fa_expected(input logic [2:0] vec);
    logic s;
    logic c;
    s = vec[2] ^ vec[1] ^ vec[0];
    c = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    return {s, c};
  endfunction

endpackage

// File: rtl/fulladder_bist_cmp.sv
// Combinational golden compare of an observed {sum,cout} against the reference model.
module fulladder_bist_cmp
  import fulladder_pkg::*;
(
  input  logic [2:0] vec,
  input  logic [1:0] resp,
  output logic       mismatch_c
);

  assign mismatch_c = (resp != fa_expected(vec));

endmodule

// File: rtl/fulladder_bist.sv
// Stimulus/response engine: sweeps all full-adder input patterns, checks each
// response after a settle time, counts mismatches and records the first one.
module fulladder_bist
  import fulladder_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec,
  output logic [1:0]       first_fail_resp
);

  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SET_W-1:0]  SETTLE_INIT = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
  localparam logic [2:0]        VEC_LAST    = 3'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  state_t            state, state_nxt;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_nxt;
  logic [PASS_W-1:0] pass_idx, pass_idx_nxt;
  logic [2:0]        vec, vec_nxt;
  logic              busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic [2:0]        first_fail_vec_nxt;
  logic [1:0]        first_fail_resp_nxt;
  logic              mismatch_c;

  // The vector register directly drives the adder inputs
  assign {a, b, cin} = vec;

  fulladder_bist_cmp u_cmp (
    .vec        (vec),
    .resp       ({sum, cout}),
    .mismatch_c (mismatch_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      settle_cnt      <= '0;
      pass_idx        <= '0;
      vec             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      fail_valid      <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_resp <= '0;
    end else begin
      state           <= state_nxt;
      settle_cnt      <= settle_cnt_nxt;
      pass_idx        <= pass_idx_nxt;
      vec             <= vec_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
      pass            <= pass_nxt;
      err_cnt         <= err_cnt_nxt;
      fail_valid      <= fail_valid_nxt;
      first_fail_vec  <= first_fail_vec_nxt;
      first_fail_resp <= first_fail_resp_nxt;
    end
  end

  always_comb begin
    state_nxt           = state;
    settle_cnt_nxt      = settle_cnt;
    pass_idx_nxt        = pass_idx;
    vec_nxt             = vec;
    busy_nxt            = busy;
    done_nxt            = done;
    pass_nxt            = pass;
    err_cnt_nxt         = err_cnt;
    fail_valid_nxt      = fail_valid;
    first_fail_vec_nxt  = first_fail_vec;
    first_fail_resp_nxt = first_fail_resp;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt           = SETTLE;
          vec_nxt             = '0;
          settle_cnt_nxt      = SETTLE_INIT;
          pass_idx_nxt        = '0;
          busy_nxt            = 1'b1;
          done_nxt            = 1'b0;
          pass_nxt            = 1'b0;
          err_cnt_nxt         = '0;
          fail_valid_nxt      = 1'b0;
          first_fail_vec_nxt  = '0;
          first_fail_resp_nxt = '0;
        end
      end

      SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt - SET_W'(1);
        end
      end

      CHECK: begin
        if (mismatch_c) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt_nxt = err_cnt + ERR_W'(1);
          end
          if (!fail_valid) begin
            fail_valid_nxt      = 1'b1;
            first_fail_vec_nxt  = vec;
            first_fail_resp_nxt = {sum, cout};
          end
        end
        if (vec == VEC_LAST && pass_idx == PASS_LAST) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          vec_nxt   = '0;
          // fail_valid still reflects earlier vectors; this CHECK adds mismatch_c
          pass_nxt  = !fail_valid && !mismatch_c;
        end else begin
          if (vec == VEC_LAST) begin
            pass_idx_nxt = pass_idx + PASS_W'(1);
          end
          vec_nxt        = vec + 3'd1;
          settle_cnt_nxt = SETTLE_INIT;
          state_nxt      = SETTLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fulladder_bist.sv
// Scoreboard bench: two BIST instances drive modelled adders (good or faulty);
// run results are checked against hand-computed expectations when done rises.
module tb_fulladder_bist;

  typedef struct {
    int inst;
    int pass;
    int err;
    int fv;
    int fvec;
    int fresp;
    int lat;
    int nvec;
  } exp_t;

  logic clk;
  logic rst;
  logic start [2];
  int   mode  [2];

  logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fv0;
  logic [3:0] err0;
  logic [2:0] ffv0;
  logic [1:0] ffr0;
  logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fv1;
  logic [1:0] err1;
  logic [2:0] ffv1;
  logic [1:0] ffr1;

  int errs = 0;
  int chk  = 0;
  exp_t exp_q[$];

  // mode 0: good adder, 1: sum stuck-at-0, 2: both outputs inverted
  function automatic logic [1:0] fa_model(input int md, input logic [2:0] v);
    logic [1:0] g;
    g = {v[2] ^ v[1] ^ v[0], (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])};
    case (md)
      1:       return {1'b0, g[0]};
      2:       return ~g;
      default: return g;
    endcase
  endfunction

  assign {s0, co0} = fa_model(mode[0], {a0, b0, c0});
  assign {s1, co1} = fa_model(mode[1], {a1, b1, c1});

  fulladder_bist u0 (
    .clk(clk), .rst(rst), .start(start[0]), .a(a0), .b(b0), .cin(c0),
    .sum(s0), .cout(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_valid(fv0), .first_fail_vec(ffv0), .first_fail_resp(ffr0)
  );

  fulladder_bist #(.SETTLE_CYCLES(3), .PASSES(2), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .cout(co1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .first_fail_vec(ffv1), .first_fail_resp(ffr1)
  );

  logic [2:0] vec_v  [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       pass_v [2];
  logic       fv_v   [2];
  logic [3:0] err_v  [2];
  logic [2:0] ffv_v  [2];
  logic [1:0] ffr_v  [2];

  assign vec_v[0] = {a0, b0, c0};
  assign vec_v[1] = {a1, b1, c1};
  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign pass_v[0] = pass0;
  assign pass_v[1] = pass1;
  assign fv_v[0] = fv0;
  assign fv_v[1] = fv1;
  assign err_v[0] = err0;
  assign err_v[1] = {2'b00, err1};
  assign ffv_v[0] = ffv0;
  assign ffv_v[1] = ffv1;
  assign ffr_v[0] = ffr0;
  assign ffr_v[1] = ffr1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_zero(input int i);
    logic [15:0] all;
    all = {vec_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fv_v[i], ffv_v[i], ffr_v[i]};
    check($sformatf("outputs_zero_u%0d", i), 32'(all), 32'd0);
  endtask

  // Monitor: tracks run latency and the vector walk, checks results on done rise
  int         cyc     [2];
  int         walk_n  [2];
  logic       walk_ok [2];
  logic [2:0] last_v  [2];
  logic       busy_p  [2];
  logic       done_p  [2];
  exp_t       mon_e;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        cyc[i] = 0; walk_n[i] = 0; walk_ok[i] = 1'b1;
        busy_p[i] = 1'b0; done_p[i] = 1'b0;
      end else begin
        if (busy_v[i]) begin
          if (!busy_p[i]) begin
            cyc[i] = 0; walk_n[i] = 0; walk_ok[i] = 1'b1;
          end
          cyc[i]++;
          if (walk_n[i] == 0 || vec_v[i] != last_v[i]) begin
            if (int'(vec_v[i]) != walk_n[i] % 8) walk_ok[i] = 1'b0;
            last_v[i] = vec_v[i];
            walk_n[i]++;
          end
        end
        if (done_v[i] && !done_p[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_done_u%0d", i), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("inst",       32'(i),          32'(mon_e.inst));
            check("pass",       32'(pass_v[i]),  32'(mon_e.pass));
            check("err_cnt",    32'(err_v[i]),   32'(mon_e.err));
            check("fail_valid", 32'(fv_v[i]),    32'(mon_e.fv));
            check("first_vec",  32'(ffv_v[i]),   32'(mon_e.fvec));
            check("first_resp", 32'(ffr_v[i]),   32'(mon_e.fresp));
            check("latency",    32'(cyc[i]),     32'(mon_e.lat));
            check("walk_order", 32'(walk_ok[i]), 32'd1);
            check("walk_len",   32'(walk_n[i]),  32'(mon_e.nvec));
            check("busy_low",   32'(busy_v[i]),  32'd0);
          end
        end
        busy_p[i] = busy_v[i];
        done_p[i] = done_v[i];
      end
    end
  end

  task automatic wait_done(input int i);
    int k;
    k = 0;
    while (!done_v[i] && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!done_v[i]) check($sformatf("timeout_u%0d", i), 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int i, input int md, input exp_t e, input bit poke);
    mode[i] = md;
    exp_q.push_back(e);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    check("clear_err", 32'(err_v[i]), 32'd0);
    check("clear_fv",  32'(fv_v[i]),  32'd0);
    check("busy_high", 32'(busy_v[i]), 32'd1);
    if (poke) begin
      repeat (10) @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      repeat (20) @(negedge clk);
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
    end
    wait_done(i);
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0; start[1] = 1'b0;
    mode[0] = 0; mode[1] = 0;
    repeat (2) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rst = 1'b0;

    // u0 defaults: good adder, then sum stuck-at-0, then good again from DONE
    run(0, 0, '{inst:0, pass:1, err:0, fv:0, fvec:0, fresp:0, lat:16, nvec:8}, 1'b0);
    run(0, 1, '{inst:0, pass:0, err:4, fv:1, fvec:1, fresp:0, lat:16, nvec:8}, 1'b0);
    run(0, 0, '{inst:0, pass:1, err:0, fv:0, fvec:0, fresp:0, lat:16, nvec:8}, 1'b0);

    // u1 (settle 3, two sweeps, 2-bit counter): inverted adder saturates at 3
    run(1, 2, '{inst:1, pass:0, err:3, fv:1, fvec:0, fresp:3, lat:64, nvec:16}, 1'b0);
    run(1, 0, '{inst:1, pass:1, err:0, fv:0, fvec:0, fresp:0, lat:64, nvec:16}, 1'b1);

    // Abort a faulty run mid-way; outputs must clear without waiting for a clock
    mode[0] = 1;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_had_errors", 32'(fv_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_zero(0);
    @(negedge clk);
    #2 rst = 1'b0;
    run(0, 0, '{inst:0, pass:1, err:0, fv:0, fvec:0, fresp:0, lat:16, nvec:8}, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, chk);
    $finish;
  end

endmodule
